// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the 4:1 round-robin mux arbiter.
package mux_arb_pkg;
   localparam int N_SRC = 4;
   localparam int SEL_W = 2;

   typedef logic [SEL_W-1:0] sel_t;

   typedef enum logic {ST_EMPTY, ST_FULL} stage_e;
endpackage

// File: rtl/mux_41_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping mod 4.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [N_SRC-1:0] req,
   input  sel_t             ptr,
   output logic             any,
   output sel_t             winner,
   output logic [N_SRC-1:0] onehot
);
   logic found;
   sel_t idx;

   always_comb begin
      any    = |req;
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < N_SRC; k++) begin
         // sel_t arithmetic gives the 3 -> 0 wrap for free
         idx = ptr + sel_t'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
      onehot = any ? (N_SRC'(1) << winner) : '0;
   end
endmodule

// File: rtl/mux_41_rr_arbiter.sv
// Round-robin 4:1 arbiter with a one-entry registered output stage (valid/ready).
module mux_41_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W = 8
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_SRC-1:0]        req_valid,
   input  logic [N_SRC*DATA_W-1:0] req_data,
   output logic [N_SRC-1:0]        req_ready,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   output logic [SEL_W-1:0]        out_sel,
   input  logic                    out_ready,
   output logic                    busy
);
   logic [N_SRC-1:0][DATA_W-1:0] words;
   logic [N_SRC-1:0]             onehot;
   sel_t                         ptr;
   sel_t                         winner;
   logic                         any;
   logic                         accept;
   stage_e                       st, st_nxt;

   assign words = req_data;

   rr_pick4 u_pick (
      .req    (req_valid),
      .ptr    (ptr),
      .any    (any),
      .winner (winner),
      .onehot (onehot)
   );

   assign out_valid = (st == ST_FULL);
   // rst_n gates accept so no grant leaks out during a reset cycle
   assign accept    = rst_n & any & (~out_valid | out_ready);
   assign req_ready = accept ? onehot : '0;
   assign busy      = out_valid | any;

   always_comb begin
      st_nxt = st;
      if (accept)
         st_nxt = ST_FULL;
      else if (out_valid && out_ready)
         st_nxt = ST_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) st <= ST_EMPTY;
      else        st <= st_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data <= '0;
         out_sel  <= '0;
         ptr      <= '0;
      end else if (accept) begin
         out_data <= words[winner];
         out_sel  <= winner;
         ptr      <= winner + sel_t'(1);
      end
   end
endmodule

// File: tb/tb_mux_41_rr_arbiter.sv
// Scoreboard bench for mux_41_rr_arbiter: directed grants push expected words, monitor pops on handshake.
module tb_mux_41_rr_arbiter;
   localparam int DATA_W = 8;

   typedef struct packed {
      logic [1:0]        sel;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [3:0]          req_valid;
   logic [4*DATA_W-1:0] req_data;
   logic [3:0]          req_ready;
   logic                out_valid;
   logic [DATA_W-1:0]   out_data;
   logic [1:0]          out_sel;
   logic                out_ready;
   logic                busy;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   mux_41_rr_arbiter #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // settle combinational outputs, then check the grant
   task automatic grant(input logic [3:0] exp_rdy, input logic [1:0] sel, input logic [7:0] data);
      #1;
      chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
      exp_q.push_back('{sel: sel, data: data});
   endtask

   task automatic no_grant(input string name);
      #1;
      chk(name, {28'd0, req_ready}, 32'd0);
   endtask

   // monitor: handshake pops scoreboard, plus grant invariants every cycle
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_n === 1'b0) begin
            if (req_ready !== 4'b0000) begin
               n_vec++; n_err++;
               $display("FAIL rst_ready: got %b expected 0000", req_ready);
            end
         end else begin
            if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != 4'b0000)) begin
               n_vec++; n_err++;
               $display("FAIL ready_legal: got %b with req_valid %b", req_ready, req_valid);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
               if (exp_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_out: got sel %0d data %0h expected nothing", out_sel, out_data);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("out_sel", {30'd0, out_sel}, {30'd0, e.sel});
                  chk("out_data", {24'd0, out_data}, {24'd0, e.data});
               end
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'hF;
      req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      out_ready = 1'b1;

      // 1: reset with everyone requesting
      step();
      mon_en = 1'b1;
      no_grant("rst_ready0");
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", {24'd0, out_data}, 32'd0);
      chk("rst_sel", {30'd0, out_sel}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      step();
      no_grant("rst_ready1");

      // 3: continuous requests from reset, grant order 0,1,2,3,0 with no bubbles
      rst_n = 1'b1;
      grant(4'b0001, 2'd0, 8'h10);
      step();
      chk("full_c1", {31'd0, out_valid}, 32'd1);
      grant(4'b0010, 2'd1, 8'h11);
      step();
      chk("full_c2", {31'd0, out_valid}, 32'd1);
      grant(4'b0100, 2'd2, 8'h12);
      step();
      chk("full_c3", {31'd0, out_valid}, 32'd1);
      grant(4'b1000, 2'd3, 8'h13);
      step();
      chk("full_c4", {31'd0, out_valid}, 32'd1);
      grant(4'b0001, 2'd0, 8'h10);
      step();
      chk("full_c5", {31'd0, out_valid}, 32'd1);

      // 2: single requester 2 (drain and refill in the same cycle), ptr -> 3
      req_valid = 4'b0100;
      req_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
      grant(4'b0100, 2'd2, 8'hA5);
      step();
      req_valid = 4'b0000;
      chk("t2_valid", {31'd0, out_valid}, 32'd1);
      chk("t2_data", {24'd0, out_data}, 32'h0A5);
      chk("t2_sel", {30'd0, out_sel}, 32'd2);
      step();
      chk("t2_drained", {31'd0, out_valid}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // 5: bring ptr to 1 via requester 0, then 1001 -> 3 then 0 (wrap)
      req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      req_valid = 4'b0001;
      grant(4'b0001, 2'd0, 8'h10);
      step();
      req_valid = 4'b1001;
      grant(4'b1000, 2'd3, 8'h13);
      step();
      grant(4'b0001, 2'd0, 8'h10);
      step();
      req_valid = 4'b0000;
      step();

      // 4: ptr=1; fill, then stall 5 cycles with all requesting
      req_valid = 4'b1111;
      grant(4'b0010, 2'd1, 8'h11);
      step();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         no_grant("stall_ready");
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_data", {24'd0, out_data}, 32'h011);
         chk("stall_sel", {30'd0, out_sel}, 32'd1);
         step();
      end
      out_ready = 1'b1;
      grant(4'b0100, 2'd2, 8'h12);
      step();
      req_valid = 4'b0000;
      step();

      // 6: ptr=3; fill, stall, then reset discards the held word
      req_valid = 4'b1111;
      grant(4'b1000, 2'd3, 8'h13);
      step();
      out_ready = 1'b0;
      rst_n     = 1'b0;
      no_grant("midrst_ready");
      exp_q.delete();
      step();
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_sel", {30'd0, out_sel}, 32'd0);
      chk("midrst_data", {24'd0, out_data}, 32'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      grant(4'b0001, 2'd0, 8'h10);
      step();
      req_valid = 4'b0000;
      step();
      step();

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
